// File: rtl/vga_fb_pkg.sv
// Shared constants for the 800x600 framebuffer path: VGA timing, framebuffer geometry,
// and the state encoding of the scanout/writer arbiter.
package vga_fb_pkg;

  localparam int H_VISIBLE  = 800;
  localparam int H_FRONT    = 56;
  localparam int H_SYNC     = 120;
  localparam int H_BACK     = 64;
  localparam int WHOLE_LINE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE   = 600;
  localparam int V_FRONT     = 37;
  localparam int V_SYNC      = 6;
  localparam int V_BACK      = 23;
  localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int FB_DATA_W         = 16;
  localparam int FB_ADDR_W         = 17;
  localparam int FB_WORDS_PER_LINE = 200;
  localparam int FB_LINES          = 600;
  localparam int FB_LINE_W         = 10;
  localparam int FB_WRITE_SLOT     = 8;
  localparam int LB_ADDR_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Line-fetch address generator: line base register, word counter, and the one-cycle
// delayed line-buffer write strobe/index that tracks the RAM read latency.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W         = FB_ADDR_W,
  parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
  parameter int LINE_W         = FB_LINE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [LINE_W-1:0]    i_line,
  input  logic                 i_rd,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic                 o_last,
  output logic                 o_lb_wr_en,
  output logic [LB_ADDR_W-1:0] o_lb_wr_addr,
  output logic                 o_done
);

  localparam logic [LB_ADDR_W-1:0] LAST_WORD = LB_ADDR_W'(WORDS_PER_LINE - 1);

  logic [ADDR_W-1:0]    r_base;
  logic [LB_ADDR_W-1:0] r_word_cnt;
  logic                 r_lb_wr_en;
  logic [LB_ADDR_W-1:0] r_lb_wr_addr;
  logic                 r_done;

  // Base is pure datapath; it is only observed while a fetch is in flight.
  always_ff @(posedge clk) begin
    if (i_load) r_base <= ADDR_W'(i_line) * ADDR_W'(WORDS_PER_LINE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt   <= '0;
      r_lb_wr_en   <= 1'b0;
      r_lb_wr_addr <= '0;
      r_done       <= 1'b0;
    end else begin
      if (i_load)    r_word_cnt <= '0;
      else if (i_rd) r_word_cnt <= r_word_cnt + LB_ADDR_W'(1);
      r_lb_wr_en <= i_rd;
      if (i_rd) r_lb_wr_addr <= r_word_cnt;
      r_done <= i_rd & o_last;
    end
  end

  assign o_rd_addr    = r_base + ADDR_W'(r_word_cnt);
  assign o_last       = (r_word_cnt == LAST_WORD);
  assign o_lb_wr_en   = r_lb_wr_en;
  assign o_lb_wr_addr = r_lb_wr_addr;
  assign o_done       = r_done;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout line prefetch has priority, the pixel writer
// gets a guaranteed slot every WRITE_SLOT cycles. Optional stats via VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int DATA_W         = FB_DATA_W,
  parameter int ADDR_W         = FB_ADDR_W,
  parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
  parameter int LINES          = FB_LINES,
  parameter int LINE_W         = FB_LINE_W,
  parameter int WRITE_SLOT     = FB_WRITE_SLOT
) (
  input  logic                 VGA_CLK,
  input  logic                 VGA_RST_N,
  input  logic                 fetch_req,
  input  logic [LINE_W-1:0]    fetch_line,
  output logic                 fetch_busy,
  output logic                 fetch_done,
  output logic                 fetch_overrun,
  input  logic                 err_clr,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 lb_wr_en,
  output logic [LB_ADDR_W-1:0] lb_wr_addr,
  output logic [DATA_W-1:0]    lb_wr_data
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]          overrun_cnt,
  output logic [15:0]          wr_stall_cnt
`endif
);

  localparam int               SLOT_W    = $clog2(WRITE_SLOT);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WRITE_SLOT - 1);

  fb_state_e         r_state;
  logic [SLOT_W-1:0] r_slot;
  logic              r_busy;
  logic              r_overrun;

  logic              w_idle;
  logic              w_accept;
  logic              w_slot_turn;
  logic              w_ready_st;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_last;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & fetch_req & (32'(fetch_line) < LINES);
  assign w_slot_turn = (r_state == ST_FETCH) & (r_slot == SLOT_LAST);

  // In the acceptance cycle the fetch wins; the writer waits for its first slot.
  always_comb begin
    w_ready_st = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready_st = ~w_accept;
      ST_FETCH: w_ready_st = w_slot_turn;
      ST_DRAIN: w_ready_st = 1'b1;
      default:  w_ready_st = 1'b0;
    endcase
  end

  assign wr_ready = VGA_RST_N & w_ready_st;
  assign w_wr_go  = wr_valid & wr_ready;
  assign w_rd_go  = (r_state == ST_FETCH) & ~(w_slot_turn & wr_valid);

  assign mem_en    = w_wr_go | w_rd_go;
  assign mem_we    = w_wr_go;
  assign mem_addr  = w_wr_go ? wr_addr : (w_rd_go ? w_rd_addr : '0);
  assign mem_wdata = w_wr_go ? wr_data : '0;

  vga_fb_addr_gen #(
    .ADDR_W         (ADDR_W),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINE_W         (LINE_W)
  ) u_addr_gen (
    .clk          (VGA_CLK),
    .rst_n        (VGA_RST_N),
    .i_load       (w_accept),
    .i_line       (fetch_line),
    .i_rd         (w_rd_go),
    .o_rd_addr    (w_rd_addr),
    .o_last       (w_last),
    .o_lb_wr_en   (lb_wr_en),
    .o_lb_wr_addr (lb_wr_addr),
    .o_done       (fetch_done)
  );

  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (fetch_req & ~w_idle) r_overrun <= 1'b1;
      else if (err_clr)        r_overrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_FETCH;
            r_slot  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
          if (w_rd_go & w_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_busy    = r_busy;
  assign fetch_overrun = r_overrun;
  assign lb_wr_data    = mem_rdata;

`ifdef VGA_FB_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_overrun_cnt;
  logic [15:0] r_wr_stall_cnt;
  logic        w_drop;
  logic        w_stall;

  assign w_drop  = fetch_req & ~w_idle;
  assign w_stall = wr_valid & ~wr_ready;

  // An event in the same cycle as err_clr survives the clear and counts as one.
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      r_overrun_cnt  <= '0;
      r_wr_stall_cnt <= '0;
    end else begin
      if (w_drop)       r_overrun_cnt <= err_clr ? 16'd1 : sat_inc(r_overrun_cnt);
      else if (err_clr) r_overrun_cnt <= '0;
      if (w_stall)      r_wr_stall_cnt <= err_clr ? 16'd1 : sat_inc(r_wr_stall_cnt);
      else if (err_clr) r_wr_stall_cnt <= '0;
    end
  end

  assign overrun_cnt  = r_overrun_cnt;
  assign wr_stall_cnt = r_wr_stall_cnt;
`endif

endmodule
